// File: rtl/mc6845_host_writer_if.sv
// rtl/mc6845_host_writer_if.sv - request port and CRTC CPU-bus bundle for mc6845_host_writer
//
// Purpose: groups the write-request handshake and the MC6845 CPU bus so the
// writer and its host/target see one connection.
// Signals:
//   req_valid/req_ready/req_addr[4:0]/req_data[7:0]  write request handshake
//   done, busy                                       request status
//   E, CSn, RS, RW, D[7:0]                           MC6845 CPU bus
// Modports: slave = the writer, master = the requester/observer side.
interface mc6845_host_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_addr;
  logic [7:0] req_data;
  logic       done;
  logic       busy;
  logic       E;
  logic       CSn;
  logic       RS;
  logic       RW;
  logic [7:0] D;

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, done, busy, E, CSn, RS, RW, D
  );

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, done, busy, E, CSn, RS, RW, D
  );
endinterface

// File: rtl/mc6845_host_writer.sv
// rtl/mc6845_host_writer.sv - bus initiator that programs an MC6845 CRTC register file
//
// Purpose: takes register write requests and issues an address-register write
// (RS=0) followed by a data-register write (RS=1) on the CRTC CPU bus. The
// address cycle is skipped when the target's address register already holds
// the requested index.
// Optional feature: define CRTC_BOOT_INIT_EN to write a 16-entry MDA 80x25
// table to R0..R15 right after reset, before host requests are accepted.
// Ports:
//   CLK   in  system clock, rising edge
//   RSTn  in  asynchronous active-low reset
//   bus   slave modport of mc6845_host_writer_if (request port + CRTC bus)
module mc6845_host_writer #(
  parameter int SETUP_CYC  = 1,
  parameter int E_HIGH_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  mc6845_host_writer_if.slave   bus
);

  localparam int MAX_SE  = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int MAX_CYC = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_EHI, A_HOLD, D_SETUP, D_EHI, D_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [4:0]    cache_q, cache_d;
  logic          cache_valid_q, cache_valid_d;

  logic          e_q, e_d;
  logic          csn_q, csn_d;
  logic          rs_q, rs_d;
  logic          rw_q, rw_d;
  logic [7:0]    dbus_q, dbus_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;

  logic          done_ev;
  logic          start;
  logic [4:0]    start_addr;
  logic [7:0]    start_data;
  logic          boot_busy, boot_busy_next;
  logic [4:0]    boot_addr;
  logic [7:0]    boot_data;
  logic          a_phase, d_phase;

  // Counter reload value for the phase being entered; a phase ends when cnt reaches 0.
  function automatic logic [CW-1:0] phase_len(input state_t s);
    case (s)
      A_SETUP, D_SETUP: phase_len = CW'(SETUP_CYC - 1);
      A_EHI,   D_EHI:   phase_len = CW'(E_HIGH_CYC - 1);
      A_HOLD,  D_HOLD:  phase_len = CW'(HOLD_CYC - 1);
      default:          phase_len = '0;
    endcase
  endfunction

  assign done_ev = (state_q == D_HOLD) && (cnt_q == '0);

`ifdef CRTC_BOOT_INIT_EN
  localparam logic RST_READY = 1'b0;
  localparam logic RST_BUSY  = 1'b1;

  logic       boot_q, boot_d;
  logic [3:0] boot_idx_q, boot_idx_d;

  function automatic logic [7:0] boot_rom(input logic [3:0] i);
    case (i)
      4'd0:  boot_rom = 8'h61;
      4'd1:  boot_rom = 8'h50;
      4'd2:  boot_rom = 8'h52;
      4'd3:  boot_rom = 8'h0F;
      4'd4:  boot_rom = 8'h19;
      4'd5:  boot_rom = 8'h06;
      4'd6:  boot_rom = 8'h19;
      4'd7:  boot_rom = 8'h19;
      4'd8:  boot_rom = 8'h02;
      4'd9:  boot_rom = 8'h0D;
      4'd10: boot_rom = 8'h0B;
      4'd11: boot_rom = 8'h0C;
      default: boot_rom = 8'h00;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      boot_q     <= 1'b1;
      boot_idx_q <= 4'd0;
    end else begin
      boot_q     <= boot_d;
      boot_idx_q <= boot_idx_d;
    end
  end

  // Advance one ROM entry per completed data cycle; the last done ends boot.
  always_comb begin
    boot_d     = boot_q;
    boot_idx_d = boot_idx_q;
    if (boot_q && done_ev) begin
      if (boot_idx_q == 4'd15) boot_d = 1'b0;
      else                     boot_idx_d = boot_idx_q + 4'd1;
    end
  end

  assign boot_busy      = boot_q;
  assign boot_busy_next = boot_d;
  assign boot_addr      = {1'b0, boot_idx_q};
  assign boot_data      = boot_rom(boot_idx_q);
`else
  localparam logic RST_READY = 1'b1;
  localparam logic RST_BUSY  = 1'b0;

  assign boot_busy      = 1'b0;
  assign boot_busy_next = 1'b0;
  assign boot_addr      = 5'd0;
  assign boot_data      = 8'd0;
`endif

  // Boot entries take priority; host requests only start while ready_q is high.
  assign start      = (state_q == IDLE) && (boot_busy || (bus.req_valid && ready_q));
  assign start_addr = boot_busy ? boot_addr : bus.req_addr;
  assign start_data = boot_busy ? boot_data : bus.req_data;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= 5'd0;
      data_q        <= 8'd0;
      cache_q       <= 5'd0;
      cache_valid_q <= 1'b0;
      e_q           <= 1'b0;
      csn_q         <= 1'b1;
      rs_q          <= 1'b0;
      rw_q          <= 1'b1;
      dbus_q        <= 8'd0;
      done_q        <= 1'b0;
      busy_q        <= RST_BUSY;
      ready_q       <= RST_READY;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cache_q       <= cache_d;
      cache_valid_q <= cache_valid_d;
      e_q           <= e_d;
      csn_q         <= csn_d;
      rs_q          <= rs_d;
      rw_q          <= rw_d;
      dbus_q        <= dbus_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    cache_d       = cache_q;
    cache_valid_d = cache_valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          data_d  = start_data;
          state_d = (cache_valid_q && (start_addr == cache_q)) ? D_SETUP : A_SETUP;
        end
      end
      A_SETUP: if (cnt_q == '0) state_d = A_EHI;
      A_EHI:   if (cnt_q == '0) state_d = A_HOLD;
      A_HOLD: begin
        if (cnt_q == '0) begin
          state_d       = D_SETUP;
          cache_d       = addr_q;
          cache_valid_d = 1'b1;
        end
      end
      D_SETUP: if (cnt_q == '0) state_d = D_EHI;
      D_EHI:   if (cnt_q == '0) state_d = D_HOLD;
      D_HOLD:  if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every phase moves to a different state, so a state change marks a reload.
    if (state_d != state_q)     cnt_d = phase_len(state_d);
    else if (state_q != IDLE)   cnt_d = cnt_q - CW'(1);

    // Bus outputs are registered from the next state so they change together
    // with the phase; RS/D only move across SETUP/HOLD boundaries where E=0.
    a_phase = (state_d == A_SETUP) || (state_d == A_EHI) || (state_d == A_HOLD);
    d_phase = (state_d == D_SETUP) || (state_d == D_EHI) || (state_d == D_HOLD);
    e_d     = (state_d == A_EHI) || (state_d == D_EHI);
    csn_d   = (state_d == IDLE);
    rw_d    = (state_d == IDLE);
    rs_d    = d_phase;
    dbus_d  = a_phase ? {3'b000, addr_d} : (d_phase ? data_d : 8'h00);
    done_d  = done_ev;
    busy_d  = (state_d != IDLE) || boot_busy_next;
    ready_d = (state_d == IDLE) && !boot_busy_next;
  end

  assign bus.E         = e_q;
  assign bus.CSn       = csn_q;
  assign bus.RS        = rs_q;
  assign bus.RW        = rw_q;
  assign bus.D         = dbus_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.req_ready = ready_q;

endmodule

// File: tb/tb_mc6845_host_writer.sv
// tb/tb_mc6845_host_writer.sv - self-checking bench for mc6845_host_writer
module tb_mc6845_host_writer;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  mc6845_host_writer_if bus();

  mc6845_host_writer dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Target CRTC model: latches on falling E while selected for write.
  logic [7:0] tgt [0:31];
  logic [4:0] tgt_addr = 5'd0;
  logic       e_prev = 1'b0;
  logic       rs_rise = 1'b0;
  logic [7:0] d_rise = 8'd0;
  int         stable_err = 0;
  logic [8:0] wlog [$];

  always @(negedge CLK) begin
    if (bus.E === 1'b1 && !e_prev) begin
      rs_rise = bus.RS;
      d_rise  = bus.D;
    end else if (bus.E === 1'b1 && e_prev && (bus.RS !== rs_rise || bus.D !== d_rise)) begin
      stable_err++;
    end
    if (e_prev && bus.E === 1'b0 && bus.CSn === 1'b0 && bus.RW === 1'b0) begin
      wlog.push_back({bus.RS, bus.D});
      if (!bus.RS) tgt_addr = bus.D[4:0];
      else         tgt[tgt_addr] = bus.D;
    end
    e_prev = (bus.E === 1'b1);
  end

  // Reference model: what the target should hold and what its address register holds.
  logic [7:0] mregs [0:31];
  bit         mwr [0:31];
  logic [4:0] mlast = 5'd0;
  bit         mvalid = 1'b0;

`ifdef CRTC_BOOT_INIT_EN
  localparam logic [7:0] ROM [16] = '{8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19,
                                      8'h02, 8'h0D, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

  task automatic after_reset();
    mvalid = 1'b0;
`ifdef CRTC_BOOT_INIT_EN
    begin
      int dones = 0;
      int n = 0;
      while (dones < 16 && n < 400) begin
        @(posedge CLK); #1; n++;
        if (bus.done === 1'b1) dones++;
      end
      chk("boot_dones", dones, 16);
      @(posedge CLK); #1;
      chk("boot_ready", bus.req_ready, 1);
      chk("boot_busy", bus.busy, 0);
      for (int i = 0; i < 16; i++) begin
        chk("boot_reg", tgt[i], ROM[i]);
        mregs[i] = ROM[i];
        mwr[i]   = 1'b1;
      end
      mlast  = 5'd15;
      mvalid = 1'b1;
    end
`endif
  endtask

  task automatic run_write(input string tag, input logic [4:0] a, input logic [7:0] dv,
                           input int hold, input int exp_lat);
    int lat;
    int n;
    wlog.delete();
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(posedge CLK); #1; n++;
    end
    chk({tag, "_ready_before"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = dv;
    @(posedge CLK); #1;
    lat = 0;
    while (lat < 60) begin
      if (lat >= hold) bus.req_valid = 1'b0;
      else chk({tag, "_ready_while_busy"}, bus.req_ready, 0);
      @(posedge CLK); #1; lat++;
      if (bus.done === 1'b1) break;
    end
    bus.req_valid = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_ready_at_done"}, bus.req_ready, 1);
    chk({tag, "_csn_at_done"}, bus.CSn, 1);
    chk({tag, "_rw_at_done"}, bus.RW, 1);
    @(posedge CLK); #1;
    chk({tag, "_done_one_cycle"}, bus.done, 0);
    chk({tag, "_e_pulses"}, wlog.size(), (exp_lat == 8) ? 2 : 1);
    if (exp_lat == 8 && wlog.size() == 2) begin
      chk({tag, "_addr_cycle"}, wlog[0], {1'b0, 3'b000, a});
      chk({tag, "_data_cycle"}, wlog[1], {1'b1, dv});
    end else if (exp_lat == 4 && wlog.size() == 1) begin
      chk({tag, "_data_cycle"}, wlog[0], {1'b1, dv});
    end
    chk({tag, "_target_reg"}, tgt[a], dv);
    mregs[a] = dv;
    mwr[a]   = 1'b1;
    mlast    = a;
    mvalid   = 1'b1;
  endtask

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    int         hold;
    int         exp_lat;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{5'd0,  8'h61, 0, 8};
    vt[1] = '{5'd1,  8'h50, 0, 8};
    vt[2] = '{5'd1,  8'h4F, 0, 4};
    vt[3] = '{5'd5,  8'h06, 6, 8};
    vt[4] = '{5'd17, 8'hAA, 2, 8};
    vt[5] = '{5'd17, 8'h55, 3, 4};
    vt[6] = '{5'd0,  8'h00, 0, 8};

    bus.req_valid = 1'b0;
    bus.req_addr  = 5'd0;
    bus.req_data  = 8'd0;
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_E", bus.E, 0);
    chk("rst_CSn", bus.CSn, 1);
    chk("rst_RW", bus.RW, 1);
    chk("rst_RS", bus.RS, 0);
    chk("rst_D", bus.D, 0);
    chk("rst_done", bus.done, 0);
`ifdef CRTC_BOOT_INIT_EN
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 1);
`else
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
`endif
    RSTn = 1'b1;
    after_reset();

    for (int i = 0; i < 7; i++) begin
      int exp_lat;
      exp_lat = vt[i].exp_lat;
`ifdef CRTC_BOOT_INIT_EN
      if (i == 0) exp_lat = 8;
`endif
      run_write($sformatf("vec%0d", i), vt[i].a, vt[i].d, vt[i].hold, exp_lat);
    end

    // Reset asserted mid data strobe: bus must release at once and the
    // address register must be treated as unknown afterwards.
    begin
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 100) begin @(posedge CLK); #1; n++; end
      bus.req_valid = 1'b1;
      bus.req_addr  = 5'd1;
      bus.req_data  = 8'h12;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0;
      n = 0;
      while (!(bus.E === 1'b1 && bus.RS === 1'b1) && n < 20) begin @(posedge CLK); #1; n++; end
      chk("abort_reached_d_ehi", (bus.E === 1'b1 && bus.RS === 1'b1), 1);
      #2;
      RSTn = 1'b0;
      #1;
      chk("abort_E", bus.E, 0);
      chk("abort_CSn", bus.CSn, 1);
      chk("abort_RW", bus.RW, 1);
      chk("abort_done", bus.done, 0);
      chk("abort_target_unchanged", tgt[1], mregs[1]);
      repeat (2) @(posedge CLK);
      #1;
      RSTn = 1'b1;
      after_reset();
      run_write("abort_rewrite", 5'd1, 8'h12, 0, (mvalid && mlast == 5'd1) ? 4 : 8);
    end

    for (int i = 0; i < 40; i++) begin
      logic [4:0] a;
      logic [7:0] d;
      int         exp_lat;
      if (mvalid && $urandom_range(0, 1) == 1) a = mlast;
      else a = 5'($urandom_range(0, 17));
      d = 8'($urandom);
      exp_lat = (mvalid && a == mlast) ? 4 : 8;
      run_write("rnd", a, d, int'($urandom_range(0, 3)), exp_lat);
    end

    for (int i = 0; i < 18; i++) begin
      if (mwr[i]) chk($sformatf("final_reg%0d", i), tgt[i], mregs[i]);
    end
    chk("rs_d_stable_while_e_high", stable_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
